// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising serial PRBS checker with lock detect and saturating error count
// Optional feature macro: PRBS_CHK_INV_EN (adds din_inv to check inverted links).
module prbs_checker #(
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
`ifdef PRBS_CHK_INV_EN
    input  logic             din_inv,
`endif
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int TAP2 = (PRBS_ORDER == 7)  ? 6  :
                          (PRBS_ORDER == 15) ? 14 :
                          (PRBS_ORDER == 23) ? 18 :
                          (PRBS_ORDER == 31) ? 28 : 0;

    generate
        if (TAP2 == 0) begin : g_bad_order
            $error("prbs_checker: PRBS_ORDER must be 7, 15, 23 or 31");
        end
        if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock
            $error("prbs_checker: LOCK_CNT must be 1..255");
        end
        if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_bad_loss
            $error("prbs_checker: LOSS_THRESH must be 1..15");
        end
    endgenerate

    localparam logic [4:0] FILL_LAST  = 5'(PRBS_ORDER - 1);
    localparam logic [7:0] MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] MISS_LAST  = 4'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        SEED   = 2'b00,
        CHECK  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [PRBS_ORDER-1:0] lfsr_q, lfsr_d;
    logic [4:0]            fill_q, fill_d;
    logic [7:0]            match_q, match_d;
    logic [3:0]            miss_q, miss_d;
    logic                  bit_err;
    logic                  d;
    logic                  pred;
    logic                  active;

`ifdef PRBS_CHK_INV_EN
    assign d = din ^ din_inv;
`else
    assign d = din;
`endif

    assign active = en & din_valid;
    assign pred   = lfsr_q[PRBS_ORDER-1] ^ lfsr_q[TAP2-1];
    assign state  = state_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        bit_err = 1'b0;
        if (active) begin
            case (state_q)
                SEED: begin
                    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], d};
                    if (fill_q == FILL_LAST) begin
                        // An all-zero window is the LFSR lock-up state; keep filling.
                        fill_d = '0;
                        if (lfsr_d != '0) begin
                            state_d = CHECK;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                CHECK: begin
                    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], pred};
                    if (d == pred) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        state_d = SEED;
                        fill_d  = '0;
                        lfsr_d  = '0;
                    end
                end
                LOCKED: begin
                    lfsr_d = {lfsr_q[PRBS_ORDER-2:0], pred};
                    if (d != pred) begin
                        bit_err = 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d = SEED;
                            fill_d  = '0;
                            lfsr_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                    lfsr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEED;
            lfsr_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= bit_err;
            // Clear has priority over a same-cycle error; the pulse still fires.
            if (clr_err) begin
                err_cnt <= '0;
            end else if (bit_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard bench for prbs_checker (default and 4-bit error counter instances)
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst, en, din, din_valid, clr_err;
    logic        inv_mode;
`ifdef PRBS_CHK_INV_EN
    logic        din_inv;
`endif
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;
    logic [1:0]  state4;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
`ifdef PRBS_CHK_INV_EN
        .din_inv   (din_inv),
`endif
        .din_valid (din_valid),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    prbs_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
`ifdef PRBS_CHK_INV_EN
        .din_inv   (din_inv),
`endif
        .din_valid (din_valid),
        .clr_err   (clr_err),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4),
        .state     (state4)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       ep;
        int         ec;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] gen;
    int         good, miss, cnt;
    int         checks = 0;
    int         errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected state follows from valid clean bits since the last resync:
    // 7 to seed, then 16 matches in CHECK, LOCKED from the 23rd onward.
    task automatic send(input string tag, input logic flip, input logic v, input logic e,
                        input logic clr, input logic zero);
        exp_t x;
        logic b;
        logic berr;
        berr = 1'b0;
        if (v && e) begin
            if (zero) begin
                b    = 1'b0;
                good = 0;
            end else begin
                b   = gen[6] ^ gen[5];
                gen = {gen[5:0], b};
                b   = b ^ flip;
                if (good >= 23) begin
                    if (flip) begin
                        berr = 1'b1;
                        cnt++;
                        miss++;
                        if (miss == 4) begin
                            good = 0;
                            miss = 0;
                        end
                    end else begin
                        miss = 0;
                    end
                end else begin
                    good++;
                end
            end
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        if (clr) cnt = 0;
        din       = b ^ inv_mode;
`ifdef PRBS_CHK_INV_EN
        din_inv   = inv_mode;
`endif
        din_valid = v;
        en        = e;
        clr_err   = clr;
        x.tag = tag;
        x.st  = (good >= 23) ? 2'b10 : (good >= 7) ? 2'b01 : 2'b00;
        x.ep  = berr;
        x.ec  = cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_eq({x.tag, ".state"},     32'(state),      32'(x.st));
        check_eq({x.tag, ".locked"},    32'(locked),     32'(x.st == 2'b10));
        check_eq({x.tag, ".err_pulse"}, 32'(err_pulse),  32'(x.ep));
        check_eq({x.tag, ".err_cnt"},   32'(err_cnt),    32'(x.ec));
        check_eq({x.tag, ".state4"},    32'(state4),     32'(x.st));
        check_eq({x.tag, ".err_cnt4"},  32'(err_cnt4),   32'((x.ec > 15) ? 15 : x.ec));
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        din_valid = 1'b0;
        clr_err   = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        good = 0;
        miss = 0;
        cnt  = 0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clr_err   = 1'b0;
        inv_mode  = 1'b0;
`ifdef PRBS_CHK_INV_EN
        din_inv   = 1'b0;
`endif
        gen  = 7'h7F;
        good = 0;
        miss = 0;
        cnt  = 0;

        #2 rst = 1'b0;
        #1;
        check_eq("reset.state",     32'(state),     32'd0);
        check_eq("reset.locked",    32'(locked),    32'd0);
        check_eq("reset.err_pulse", 32'(err_pulse), 32'd0);
        check_eq("reset.err_cnt",   32'(err_cnt),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 200; i++) send("clean", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++)
            send("single", (i == 50 || i == 80 || i == 120), 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("single.total", 32'(err_cnt), 32'd3);

        send("burst_clr", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send("burst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("burst.unlock", 32'(state), 32'd0);
        for (int i = 0; i < 40; i++) send("relock", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("burst.total", 32'(err_cnt), 32'd4);

        send("sat_clr", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            send("sat_err", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) send("sat_gap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check_eq("sat.err_cnt4", 32'(err_cnt4), 32'hF);
        check_eq("sat.err_cnt",  32'(err_cnt),  32'd20);
        send("clr_with_err", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send("post_clr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        send("pre_areset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("pre_areset.locked", 32'(locked), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("areset.locked",   32'(locked),   32'd0);
        check_eq("areset.err_cnt",  32'(err_cnt),  32'd0);
        check_eq("areset.err_cnt4", 32'(err_cnt4), 32'd0);
        check_eq("areset.state",    32'(state),    32'd0);
        #1 rst = 1'b1;
        good = 0;
        miss = 0;
        cnt  = 0;
        for (int i = 0; i < 40; i++) send("after_areset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 30; i++) send("zeros", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        do_reset();
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0)      send("gaps", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (i % 4 == 1) send("gaps", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else                 send("gaps", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_eq("gaps.locked", 32'(locked), 32'd1);

`ifdef PRBS_CHK_INV_EN
        do_reset();
        inv_mode = 1'b1;
        for (int i = 0; i < 40; i++) send("inverted", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("inverted.locked", 32'(locked), 32'd1);
        inv_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
